route_trace_decoder: RTL

- Sits on the ejection side (local port 4) of each hypercube router.
- Reads back what the route-compute stage wrote into a packet in flight: the 2-bit per-hop path symbols and the 4-bit ROUTERIDs stamped at each hop.
- Parses head and body flits and emits one trace record per hop through a valid/ready stream to the local sink and debug logger.
- Flags malformed packets.

---
 rtl/route_trace_decoder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/route_trace_decoder.sv
// Ejection-side decoder that replays the per-hop path symbols and router IDs stamped
// into a packet, emitting one trace record per hop and flagging malformed packets.
module route_trace_decoder #(
  parameter logic [3:0] ROUTERID = 4'd0,
  parameter int         MAX_HOPS = 16,
  localparam int        DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_head,
  input  logic                  in_tail,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  tr_valid,
  input  logic                  tr_ready,
  output logic [3:0]            tr_hop,
  output logic [1:0]            tr_dir,
  output logic [3:0]            tr_id,
  output logic                  tr_last,
  output logic                  pkt_done,
  output logic                  pkt_err
);

  // Flit layout: path symbols in [63:32], hop count in [21:18], head IDs in [17:2],
  // body IDs in [63:16], test bits in [1:0].
  localparam int DATA_MSB  = DATA_WIDTH - 1;
  localparam int IDX_LSB   = 18;
  localparam int BODY_BITS = 4 * (MAX_HOPS - 4);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HEAD_EMIT = 3'd1,
    WAIT_BODY = 3'd2,
    BODY_EMIT = 3'd3,
    FLUSH     = 3'd4
  } state_t;

  state_t                 state_r;
  logic [31:0]            path_r;
  logic [15:0]            head_ids_r;
  logic [BODY_BITS-1:0]   body_ids_r;
  logic [3:0]             hops_r;
  logic                   head_tail_r;
  logic                   body_tail_r;
  logic                   err_r;
  logic                   pend_r;

  logic                   accept_s;
  logic                   xfer_s;
  logic                   abort_s;
  logic [3:0]             in_hops_s;
  logic [3:0]             next_hop_s;
  logic [1:0]             next_dir_s;
  logic [3:0]             next_id_s;
  logic                   head_slot_last_s;
  logic                   body_slot_last_s;
  logic                   id_bad_s;
  logic                   unused_bits_s;

  function automatic logic [1:0] dir_of(input logic [31:0] p, input logic [3:0] k);
    logic [31:0] sh;
    sh = p << {k, 1'b0};
    return sh[31:30];
  endfunction

  function automatic logic [3:0] id_of(input logic [15:0] hids,
                                       input logic [BODY_BITS-1:0] bids,
                                       input logic [3:0] k);
    logic [15:0]          hsh;
    logic [BODY_BITS-1:0] bsh;
    logic [3:0]           j;
    j   = k - 4'd4;
    hsh = hids << {k[1:0], 2'b00};
    bsh = bids << {j, 2'b00};
    if (k < 4'd4) begin
      return hsh[15:12];
    end else begin
      return bsh[BODY_BITS-1 -: 4];
    end
  endfunction

  // Handshakes and the next record to present after the current one transfers.
  always_comb begin
    accept_s         = in_valid && in_ready;
    xfer_s           = tr_valid && tr_ready;
    abort_s          = (state_r != IDLE);
    in_hops_s        = in_data[IDX_LSB +: 4];
    next_hop_s       = tr_hop + 4'd1;
    next_dir_s       = dir_of(path_r, next_hop_s);
    next_id_s        = id_of(head_ids_r, body_ids_r, next_hop_s);
    head_slot_last_s = (next_hop_s == hops_r - 4'd1) ||
                       ((next_hop_s == 4'd3) && (hops_r > 4'd4) && head_tail_r);
    body_slot_last_s = (next_hop_s == hops_r - 4'd1);
    id_bad_s         = (tr_id != ROUTERID);
    unused_bits_s    = ^{in_data[31:22], in_data[1:0]};
  end

  // Packet FSM with registered trace stream, ready and completion outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      path_r      <= 32'd0;
      head_ids_r  <= 16'd0;
      body_ids_r  <= '0;
      hops_r      <= 4'd0;
      head_tail_r <= 1'b0;
      body_tail_r <= 1'b0;
      err_r       <= 1'b0;
      pend_r      <= 1'b0;
      in_ready    <= 1'b1;
      tr_valid    <= 1'b0;
      tr_hop      <= 4'd0;
      tr_dir      <= 2'd0;
      tr_id       <= 4'd0;
      tr_last     <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      // A local (H=0) head that aborted a packet reports its own completion one cycle late.
      if (pend_r) begin
        pkt_done <= 1'b1;
        pkt_err  <= 1'b0;
        pend_r   <= 1'b0;
        in_ready <= 1'b1;
      end
      case (state_r)
        IDLE, WAIT_BODY, FLUSH: begin
          if (accept_s && in_head) begin
            path_r      <= in_data[DATA_MSB -: 32];
            head_ids_r  <= in_data[17:2];
            hops_r      <= in_hops_s;
            head_tail_r <= in_tail;
            if (abort_s) begin
              pkt_done <= 1'b1;
              pkt_err  <= 1'b1;
            end
            if (in_hops_s == 4'd0) begin
              state_r <= in_tail ? IDLE : FLUSH;
              err_r   <= 1'b0;
              if (abort_s) begin
                pend_r   <= 1'b1;
                in_ready <= 1'b0;
              end else begin
                pkt_done <= 1'b1;
                pkt_err  <= err_r;
                in_ready <= 1'b1;
              end
            end else begin
              state_r  <= HEAD_EMIT;
              in_ready <= 1'b0;
              err_r    <= abort_s ? 1'b0 : err_r;
              tr_valid <= 1'b1;
              tr_hop   <= 4'd0;
              tr_dir   <= in_data[DATA_MSB -: 2];
              tr_id    <= in_data[17:14];
              tr_last  <= (in_hops_s == 4'd1);
            end
          end else if (accept_s) begin
            case (state_r)
              IDLE: err_r <= 1'b1;
              WAIT_BODY: begin
                body_ids_r  <= in_data[DATA_MSB -: BODY_BITS];
                body_tail_r <= in_tail;
                state_r     <= BODY_EMIT;
                in_ready    <= 1'b0;
                tr_valid    <= 1'b1;
                tr_hop      <= 4'd4;
                tr_dir      <= dir_of(path_r, 4'd4);
                tr_id       <= in_data[DATA_MSB -: 4];
                tr_last     <= (hops_r == 4'd5);
              end
              default: state_r <= in_tail ? IDLE : FLUSH;
            endcase
          end
        end
        HEAD_EMIT: begin
          if (xfer_s) begin
            if (tr_last || (tr_hop == 4'd3)) begin
              tr_valid <= 1'b0;
              tr_last  <= 1'b0;
              in_ready <= 1'b1;
              if (tr_last) begin
                pkt_done <= 1'b1;
                pkt_err  <= err_r || id_bad_s || (hops_r > 4'd4);
                err_r    <= 1'b0;
              end
              if ((hops_r > 4'd4) && !head_tail_r) begin
                state_r <= WAIT_BODY;
              end else begin
                state_r <= head_tail_r ? IDLE : FLUSH;
              end
            end else begin
              tr_hop  <= next_hop_s;
              tr_dir  <= next_dir_s;
              tr_id   <= next_id_s;
              tr_last <= head_slot_last_s;
            end
          end
        end
        BODY_EMIT: begin
          if (xfer_s) begin
            if (tr_last) begin
              tr_valid <= 1'b0;
              tr_last  <= 1'b0;
              in_ready <= 1'b1;
              pkt_done <= 1'b1;
              pkt_err  <= err_r || id_bad_s;
              err_r    <= 1'b0;
              state_r  <= body_tail_r ? IDLE : FLUSH;
            end else begin
              tr_hop  <= next_hop_s;
              tr_dir  <= next_dir_s;
              tr_id   <= next_id_s;
              tr_last <= body_slot_last_s;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          in_ready <= 1'b1;
          tr_valid <= 1'b0;
          tr_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
